// File: rtl/clahe_cdf_calc_if.sv
// rtl/clahe_cdf_calc_if.sv - CDF port of the banked tile RAM (histogram read / mapping write)
interface clahe_cdf_calc_if #(
  parameter int TILE_NUM_BITS = 6
);
  logic [TILE_NUM_BITS-1:0] cdf_tile_idx;
  logic [7:0]               cdf_addr;
  logic                     cdf_rd_en;
  logic [15:0]              cdf_rd_data;
  logic                     cdf_wr_en;
  logic [7:0]               cdf_wr_data;

  modport master (
    output cdf_tile_idx, cdf_addr, cdf_rd_en, cdf_wr_en, cdf_wr_data,
    input  cdf_rd_data
  );

  modport slave (
    input  cdf_tile_idx, cdf_addr, cdf_rd_en, cdf_wr_en, cdf_wr_data,
    output cdf_rd_data
  );
endinterface

// File: rtl/clahe_cdf_calc.sv
// rtl/clahe_cdf_calc.sv - clip-limited, redistributed, normalised CDF builder for CLAHE tiles
module clahe_cdf_calc #(
  parameter int TILE_NUM_BITS = 6,
  parameter int SCALE_MUL     = 1161,
  parameter int SCALE_SHIFT   = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             cdf_start,
  input  logic [15:0]      clip_limit,
  output logic             cdf_busy,
  output logic             cdf_done,
  clahe_cdf_calc_if.master cdf
);
  typedef enum logic [2:0] {IDLE, SCAN, EXCESS, MAP, NEXT, DONE} state_t;

  localparam logic [TILE_NUM_BITS-1:0] LAST_TILE = '1;

  state_t                   state, state_nxt;
  logic [8:0]               cnt;
  logic [TILE_NUM_BITS-1:0] tile;
  logic [15:0]              clip;
  logic [15:0]              incr;
  logic [23:0]              excess;
  logic [24:0]              cum;

  logic [15:0]              over;
  logic [15:0]              clipped;
  logic [16:0]              c;
  logic [24:0]              cum_next;
  logic [40:0]              prod;
  logic [40:0]              scaled;
  logic [7:0]               norm;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cdf_start) state_nxt = SCAN;
      SCAN:    if (cnt == 9'd256) state_nxt = EXCESS;
      EXCESS:  state_nxt = MAP;
      MAP:     if (cnt == 9'd511) state_nxt = NEXT;
      NEXT:    state_nxt = (tile == LAST_TILE) ? DONE : SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bin arithmetic; rd_data belongs to the bin addressed in the previous cycle.
  always_comb begin
    over     = (cdf.cdf_rd_data > clip) ? (cdf.cdf_rd_data - clip) : 16'd0;
    clipped  = (cdf.cdf_rd_data < clip) ? cdf.cdf_rd_data : clip;
    c        = {1'b0, clipped} + {1'b0, incr};
    cum_next = cum + {8'd0, c};
    prod     = {16'd0, cum_next} * 41'(SCALE_MUL);
    scaled   = prod >> SCALE_SHIFT;
    norm     = (scaled > 41'd255) ? 8'hff : scaled[7:0];
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tile   <= '0;
      clip   <= '0;
      incr   <= '0;
      excess <= '0;
      cum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cdf_start) begin
            clip   <= clip_limit;
            tile   <= '0;
            excess <= '0;
          end
        end
        SCAN: begin
          cnt <= (cnt == 9'd256) ? 9'd0 : cnt + 9'd1;
          if (cnt != 9'd0) excess <= excess + {8'd0, over};
        end
        EXCESS: begin
          incr <= excess[23:8];
          cum  <= '0;
          cnt  <= '0;
        end
        MAP: begin
          cnt <= cnt + 9'd1;
          if (cnt[0]) cum <= cum_next;
        end
        NEXT: begin
          excess <= '0;
          cnt    <= '0;
          if (tile != LAST_TILE) tile <= tile + 1'b1;
        end
        DONE: tile <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // MAP alternates read (even cnt) and write (odd cnt) of the same bin.
  always_comb begin
    cdf_busy         = (state != IDLE) && (state != DONE);
    cdf_done         = (state == DONE);
    cdf.cdf_tile_idx = tile;
    cdf.cdf_rd_en    = ((state == SCAN) && !cnt[8]) || ((state == MAP) && !cnt[0]);
    cdf.cdf_wr_en    = (state == MAP) && cnt[0];
    cdf.cdf_addr     = 8'd0;
    if (state == SCAN)     cdf.cdf_addr = cnt[7:0];
    else if (state == MAP) cdf.cdf_addr = cnt[8:1];
    cdf.cdf_wr_data  = cdf.cdf_wr_en ? norm : 8'd0;
  end
endmodule

// File: tb/tb_clahe_cdf_calc.sv
// tb/tb_clahe_cdf_calc.sv - scoreboard bench for clahe_cdf_calc
module tb_clahe_cdf_calc;
  localparam int TILE_CYC = 771;
  localparam int BUSY_END = 64 * TILE_CYC;
  localparam int DONE_REL = BUSY_END + 1;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cdf_start = 1'b0;
  logic [15:0] clip_limit = 16'd0;
  logic        cdf_busy;
  logic        cdf_done;

  clahe_cdf_calc_if #(.TILE_NUM_BITS(6)) bus();

  clahe_cdf_calc #(.TILE_NUM_BITS(6), .SCALE_MUL(1161), .SCALE_SHIFT(16)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .cdf_start  (cdf_start),
    .clip_limit (clip_limit),
    .cdf_busy   (cdf_busy),
    .cdf_done   (cdf_done),
    .cdf        (bus)
  );

  always #5 pclk = ~pclk;

  int edges = 0;
  always @(posedge pclk) edges <= edges + 1;

  // Tile pattern by tile%3: flat 56, single spike at bin 100, saturated.
  function automatic logic [15:0] hist(input int t, input int a);
    case (t % 3)
      0:       return 16'd56;
      1:       return (a == 100) ? 16'd14400 : 16'd0;
      default: return 16'hffff;
    endcase
  endfunction

  always @(posedge pclk)
    bus.cdf_rd_data <= bus.cdf_rd_en ? hist(int'(bus.cdf_tile_idx), int'(bus.cdf_addr)) : 16'hbeef;

  logic [21:0] exp_q[$];
  logic [7:0]  cap [0:16383];

  task automatic push_tile(input int t, input int clip);
    longint ex, inc, cum, c, v, h;
    ex = 0;
    for (int a = 0; a < 256; a++) begin
      h = longint'(hist(t, a));
      if (h > clip) ex += h - clip;
    end
    inc = ex / 256;
    cum = 0;
    for (int a = 0; a < 256; a++) begin
      h = longint'(hist(t, a));
      c = ((h < clip) ? h : clip) + inc;
      cum += c;
      v = (cum * 1161) / 65536;
      if (v > 255) v = 255;
      exp_q.push_back({6'(t), 8'(a), 8'(v)});
    end
  endtask

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int   frame_p = 0;
  logic frame_on = 1'b0;
  int   fin_code = 0;
  int   rel, exp_t, done_cnt = 0, done_rel = -1;
  int   rst_err = 0, ov_err = 0, busy_err = 0, tile_err = 0;
  logic [21:0] ent;

  always @(negedge pclk) begin
    rel = edges - frame_p + 1;
    if (rst) begin
      if (cdf_busy || cdf_done || bus.cdf_tile_idx != 6'd0 || bus.cdf_addr != 8'd0 ||
          bus.cdf_rd_en || bus.cdf_wr_en || bus.cdf_wr_data != 8'd0)
        rst_err++;
    end else begin
      if (bus.cdf_rd_en && bus.cdf_wr_en) ov_err++;
      if (cdf_done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (frame_on) begin
        if (cdf_busy !== 1'(rel >= 1 && rel <= BUSY_END)) busy_err++;
        if (rel != DONE_REL) begin
          exp_t = (rel >= 1 && rel <= BUSY_END) ? (rel - 1) / TILE_CYC : 0;
          if (int'(bus.cdf_tile_idx) != exp_t) tile_err++;
        end
      end
      if (bus.cdf_wr_en) begin
        cap[int'(bus.cdf_tile_idx) * 256 + int'(bus.cdf_addr)] = bus.cdf_wr_data;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          ent = exp_q.pop_front();
          chk("write_tile_addr_data", {bus.cdf_tile_idx, bus.cdf_addr, bus.cdf_wr_data}, ent);
        end
      end
    end
    if (fin_code == 1) begin
      chk("abort_queue_left", exp_q.size(), 0);
      chk("abort_no_done", done_cnt, 0);
      chk("reset_outputs_zero", rst_err, 0);
      chk("abort_busy_profile", busy_err, 0);
      chk("abort_tile_profile", tile_err, 0);
      exp_q.delete();
      done_cnt = 0;
      done_rel = -1;
      busy_err = 0;
      tile_err = 0;
    end
    if (fin_code == 2) begin
      chk("queue_left", exp_q.size(), 0);
      chk("done_count", done_cnt, 1);
      chk("done_cycle", done_rel, DONE_REL);
      chk("busy_profile", busy_err, 0);
      chk("tile_profile", tile_err, 0);
      chk("rd_wr_overlap", ov_err, 0);
      chk("flat_bin0", cap[0], 0);
      chk("flat_bin127", cap[127], 126);
      chk("flat_bin255", cap[255], 253);
      chk("spike_bin99", cap[256 + 99], 99);
      chk("spike_bin100", cap[256 + 100], 100);
      chk("spike_bin255", cap[256 + 255], 254);
      chk("sat_bin0", cap[512], 255);
      chk("sat_bin255", cap[512 + 255], 255);
      chk("last_tile_bin255", cap[63 * 256 + 255], 253);
    end
  end

  task automatic wait_edge(input int target);
    do begin
      @(posedge pclk);
      #1;
    end while (edges < target);
  endtask

  task automatic pulse_start(input logic [15:0] clip);
    clip_limit = clip;
    cdf_start  = 1'b1;
    @(posedge pclk);
    #1;
    cdf_start  = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    @(posedge pclk);
    #1;

    // Frame aborted by reset during tile 10 SCAN; clip 0 on flat/spike/sat tiles.
    for (int t = 0; t < 10; t++) push_tile(t, 0);
    frame_p  = edges + 1;
    frame_on = 1'b1;
    pulse_start(16'd0);
    clip_limit = 16'h1234;
    wait_edge(frame_p + 10 * TILE_CYC + 100);
    frame_on = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    fin_code = 1;
    @(posedge pclk);
    #1;
    fin_code = 0;
    repeat (2) @(posedge pclk);
    #1;

    // Full frame with clip 40, stray starts mid-frame and in the DONE cycle.
    for (int t = 0; t < 64; t++) push_tile(t, 40);
    frame_p  = edges + 1;
    frame_on = 1'b1;
    pulse_start(16'd40);
    clip_limit = 16'd0;
    wait_edge(frame_p + 4);
    pulse_start(16'd0);
    wait_edge(frame_p + 29999);
    pulse_start(16'd0);
    wait_edge(frame_p + BUSY_END);
    pulse_start(16'd0);
    wait_edge(frame_p + BUSY_END + 16);
    frame_on = 1'b0;
    fin_code = 2;
    @(posedge pclk);
    #1;
    fin_code = 0;
    @(posedge pclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
